onboth_driver: RTL and testbench

ONBOTH_DRIVER -- requirements
Module: onboth_driver

---
 rtl/onboth_driver.sv | 127 ++++++++++++
 tb/tb_onboth_driver.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/onboth_driver.sv
// onboth_driver: holds `do` high for len cycles (0 = 16), then steps RELEASE/TAIL/ACK and pulses done.
// The strobe checker (g/x/f/r) is compiled in only when ONBOTH_DRIVER_CHECK_EN is defined.
module onboth_driver (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [3:0] len_i,
  input  logic       abort_i,
  input  logic       g_i,
  input  logic       x_i,
  input  logic       f_i,
  input  logic       r_i,
  output logic       do_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [1:0] err_code_o
);

  typedef enum logic [2:0] {IDLE, DRIVE, RELEASE, TAIL, ACK} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       first_q, first_d;
  logic       do_q, do_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [1:0] code_q, code_d;
  logic       chk_fail;
  logic [1:0] chk_code;

`ifdef ONBOTH_DRIVER_CHECK_EN
  always_comb begin
    chk_fail = 1'b0;
    chk_code = 2'd0;
    case (state_q)
      DRIVE:   if (first_q && !g_i) begin chk_fail = 1'b1; chk_code = 2'd0; end
      RELEASE: if (!x_i)            begin chk_fail = 1'b1; chk_code = 2'd1; end
      TAIL:    if (!(f_i && g_i))   begin chk_fail = 1'b1; chk_code = 2'd2; end
      ACK:     if (!r_i)            begin chk_fail = 1'b1; chk_code = 2'd3; end
      default: ;
    endcase
  end
`else
  logic unused_strobes;
  assign unused_strobes = ^{g_i, x_i, f_i, r_i, first_q};
  assign chk_fail = 1'b0;
  assign chk_code = 2'd0;
`endif

  // Counter holds remaining DRIVE cycles minus one, so len=0 loads 15 and gives 16 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = 1'b0;
    do_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    code_d  = code_q;
    if (state_q != IDLE && abort_i) begin
      state_d = IDLE;
    end else begin
      if (chk_fail) begin
        err_d = 1'b1;
        if (!err_q) code_d = chk_code;
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = DRIVE;
            cnt_d   = len_i - 4'd1;
            first_d = 1'b1;
            do_d    = 1'b1;
            err_d   = 1'b0;
            code_d  = 2'd0;
          end
        end
        DRIVE: begin
          if (cnt_q == 4'd0) begin
            state_d = RELEASE;
          end else begin
            cnt_d = cnt_q - 4'd1;
            do_d  = 1'b1;
          end
        end
        RELEASE: state_d = TAIL;
        TAIL:    state_d = ACK;
        ACK: begin
          state_d = IDLE;
          done_d  = !(err_q || chk_fail);
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      first_q <= 1'b0;
      do_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      do_q    <= do_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign do_o       = do_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;

endmodule

// File: tb/tb_onboth_driver.sv
// Bench for onboth_driver: directed and random steps checked against a cycle-phase model
// where k counts cycles since start was accepted (1..L drive, L+1..L+3 release/tail/ack).
module tb_onboth_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       startI, abortI, gI, xI, fI, rI;
  logic [3:0] lenI;
  logic       doO, busyO, doneO, errO;
  logic [1:0] errCodeO;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  int         mk = 0;
  int         mL = 1;
  logic       mErr = 1'b0;
  logic [1:0] mCode = 2'd0;
  logic       mDone = 1'b0;

  onboth_driver dut (
    .clk(clk), .rst(rst), .start_i(startI), .len_i(lenI), .abort_i(abortI),
    .g_i(gI), .x_i(xI), .f_i(fI), .r_i(rI),
    .do_o(doO), .busy_o(busyO), .done_o(doneO), .err_o(errO), .err_code_o(errCodeO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".do"},   {3'd0, doO},   {3'd0, (mk >= 1 && mk <= mL)});
    check({tag, ".busy"}, {3'd0, busyO}, {3'd0, (mk != 0)});
    check({tag, ".done"}, {3'd0, doneO}, {3'd0, mDone});
    check({tag, ".err"},  {3'd0, errO},  {3'd0, mErr});
    check({tag, ".code"}, {2'd0, errCodeO}, {2'd0, mCode});
  endtask

  // Advances the model by one edge using the inputs currently applied.
  task automatic modelStep();
    logic       fail;
    logic [1:0] code;
    fail  = 1'b0;
    code  = 2'd0;
    mDone = 1'b0;
    if (mk == 0) begin
      if (startI) begin
        mk = 1;
        mL = (lenI == 4'd0) ? 16 : int'(lenI);
        mErr = 1'b0;
        mCode = 2'd0;
      end
    end else if (abortI) begin
      mk = 0;
    end else begin
`ifdef ONBOTH_DRIVER_CHECK_EN
      if (mk == 1 && !gI)                  begin fail = 1'b1; code = 2'd0; end
      else if (mk == mL + 1 && !xI)        begin fail = 1'b1; code = 2'd1; end
      else if (mk == mL + 2 && !(fI && gI)) begin fail = 1'b1; code = 2'd2; end
      else if (mk == mL + 3 && !rI)        begin fail = 1'b1; code = 2'd3; end
`endif
      if (fail) begin
        if (!mErr) mCode = code;
        mErr = 1'b1;
      end
      if (mk == mL + 3) begin
        mk = 0;
        mDone = !mErr;
      end else begin
        mk++;
      end
    end
  endtask

  // strobeMode: 0 = well-behaved sequencer, 1 = sequencer never returns x, 2 = random strobes.
  task automatic applyStimulus(input string tag, input logic st, input logic [3:0] ln,
                               input logic ab, input int strobeMode);
    startI = st;
    lenI   = ln;
    abortI = ab;
    if (strobeMode == 2) begin
      {gI, xI, fI, rI} = 4'($urandom);
    end else begin
      gI = (mk == 1) || (mk == mL + 2);
      xI = (mk == mL + 1) && (strobeMode != 1);
      fI = (mk == mL + 2);
      rI = (mk == mL + 3);
    end
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1;
    {startI, abortI, gI, xI, fI, rI} = '0;
    lenI = 4'd0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset");
    rst = 1'b0;

    applyStimulus("nominal", 1'b1, 4'd1, 1'b0, 0);
    for (int i = 0; i < 6; i++) applyStimulus("nominal", 1'b0, 4'd1, 1'b0, 0);

    applyStimulus("len0", 1'b1, 4'd0, 1'b0, 0);
    for (int i = 0; i < 21; i++) applyStimulus("len0", 1'b0, 4'd0, 1'b0, 0);

    applyStimulus("missx", 1'b1, 4'd3, 1'b0, 1);
    for (int i = 0; i < 8; i++) applyStimulus("missx", 1'b0, 4'd3, 1'b0, 1);

    applyStimulus("abort", 1'b1, 4'd5, 1'b0, 0);
    applyStimulus("abort", 1'b0, 4'd5, 1'b0, 0);
    applyStimulus("abort", 1'b0, 4'd5, 1'b1, 0);
    for (int i = 0; i < 3; i++) applyStimulus("abort", 1'b0, 4'd5, 1'b0, 0);

    for (int i = 0; i < 20; i++) applyStimulus("b2b", 1'b1, 4'd2, 1'b0, 0);
    applyStimulus("b2b", 1'b0, 4'd2, 1'b0, 0);
    for (int i = 0; i < 6; i++) applyStimulus("b2b", 1'b0, 4'd2, 1'b0, 0);

    applyStimulus("arst", 1'b1, 4'd8, 1'b0, 0);
    applyStimulus("arst", 1'b0, 4'd8, 1'b0, 0);
    applyStimulus("arst", 1'b0, 4'd8, 1'b0, 0);
    #2 rst = 1'b1;
    mk = 0; mErr = 1'b0; mCode = 2'd0; mDone = 1'b0;
    #1 checkOutput("arst.async");
    #1 rst = 1'b0;
    applyStimulus("postrst", 1'b1, 4'd2, 1'b0, 0);
    for (int i = 0; i < 6; i++) applyStimulus("postrst", 1'b0, 4'd2, 1'b0, 0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", ($urandom_range(0, 3) == 0), 4'($urandom),
                    ($urandom_range(0, 15) == 0), int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 20; i++) applyStimulus("drain", 1'b0, 4'd1, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
